debounce_event_detector: RTL and testbench

- Consumes the already-synchronized single-bit output of the two-flop synchronizer stage, in the same clock domain.
- Rejects bounce and glitches by requiring a run of consecutive identical samples before accepting a level change.
- Emits one-cycle rise and fall event pulses, and a long-hold event.
- Sits between the synchronizer and control logic such as button, switch or external strobe handlers.

---
 rtl/debounce_event_detector.sv | 133 +++++++++++++
 tb/tb_debounce_event_detector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_event_detector.sv
// Debounces an already-synchronized level and reports rise, fall and long-hold events.
// Every output is a register, so downstream logic sees clean single-cycle pulses.
module debounce_event_detector #(
    parameter int STABLE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic hold_pulse,
    output logic held
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          level_n, rise_n, fall_n, hold_pulse_n, held_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= LOW;
            cnt        <= '0;
            hold_cnt   <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            hold_pulse <= 1'b0;
            held       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hold_cnt   <= hold_cnt_n;
            level_out  <= level_n;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
            hold_pulse <= hold_pulse_n;
            held       <= held_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        hold_cnt_n   = hold_cnt;
        level_n      = level_out;
        rise_n       = 1'b0;
        fall_n       = 1'b0;
        hold_pulse_n = 1'b0;
        held_n       = held;

        // Hold timing runs through FALL_CHK too, so a rejected dropout keeps the count.
        if (level_out) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_cnt_n   = HOLD_MAX;
                hold_pulse_n = 1'b1;
                held_n       = 1'b1;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt_n = hold_cnt + 1'b1;
            end
        end

        case (state)
            LOW: begin
                if (data_in) begin
                    state_n = RISE_CHK;
                    cnt_n   = SW'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            RISE_CHK: begin
                if (!data_in) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n    = HIGH;
                    level_n    = 1'b1;
                    rise_n     = 1'b1;
                    cnt_n      = '0;
                    hold_cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!data_in) begin
                    state_n = FALL_CHK;
                    cnt_n   = SW'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            FALL_CHK: begin
                if (data_in) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    // An accepted fall overrides a hold event landing on the same edge.
                    state_n      = LOW;
                    level_n      = 1'b0;
                    fall_n       = 1'b1;
                    held_n       = 1'b0;
                    hold_pulse_n = 1'b0;
                    cnt_n        = '0;
                    hold_cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_event_detector.sv
// Randomized and directed stimulus for debounce_event_detector, scored against a
// run-length reference model; a monitor pops expected outputs after every edge.
module tb_debounce_event_detector;

    localparam int STABLE = 4;
    localparam int HOLD   = 10;

    logic clock;
    logic reset;
    logic data_in;
    logic level_out, rise_pulse, fall_pulse, hold_pulse, held;

    int errors = 0;
    int checks = 0;

    // Expected {level_out, rise_pulse, fall_pulse, hold_pulse, held} per edge.
    logic [4:0] exp_q[$];

    // Reference model state: accepted level, length of the current run of
    // samples disagreeing with it, cycles spent high, and the held flag.
    logic m_level;
    int   m_run;
    int   m_age;
    logic m_held;

    debounce_event_detector #(
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .hold_pulse(hold_pulse),
        .held      (held)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic model_step(input logic d, input logic r);
        logic prev, flip, rise, fall, hp;
        rise = 1'b0;
        fall = 1'b0;
        hp   = 1'b0;
        if (r) begin
            m_level = 1'b0;
            m_run   = 0;
            m_age   = 0;
            m_held  = 1'b0;
        end else begin
            prev = m_level;
            if (d != m_level) m_run++;
            else m_run = 0;
            flip = (m_run == STABLE);
            if (prev && m_age < HOLD + 5) m_age++;
            if (prev && m_age == HOLD && !flip) begin
                hp     = 1'b1;
                m_held = 1'b1;
            end
            if (flip) begin
                m_level = ~m_level;
                m_run   = 0;
                m_age   = 0;
                if (m_level) rise = 1'b1;
                else begin
                    fall   = 1'b1;
                    m_held = 1'b0;
                end
            end
        end
        exp_q.push_back({m_level, rise, fall, hp, m_held});
    endtask

    task automatic drive(input logic d, input logic r);
        @(negedge clock);
        data_in = d;
        reset   = r;
        model_step(d, r);
    endtask

    task automatic drive_run(input logic d, input int n);
        for (int i = 0; i < n; i++) drive(d, 1'b0);
    endtask

    // Monitor: outputs settle after each edge; compare against the oldest expectation.
    initial begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {level_out, rise_pulse, fall_pulse, hold_pulse, held};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t {level,rise,fall,hold,held} actual=%b required=%b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        logic [8:0] bounce;
        int         n;
        bounce  = 9'b1_0110_1111;
        reset   = 1'b1;
        data_in = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        m_age   = 0;
        m_held  = 1'b0;

        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);

        // Steady high gives a rise after four samples; then a steady low.
        drive_run(1'b1, 8);
        drive_run(1'b0, 8);

        // Three highs are too short to be accepted.
        drive_run(1'b1, 3);
        drive_run(1'b0, 6);

        // Bounce pattern, then long high for the hold event, then long low.
        for (int i = 8; i >= 0; i--) drive(bounce[i], 1'b0);
        drive_run(1'b1, 20);
        drive_run(1'b0, 8);

        // Short dropout mid-hold must not disturb level or hold timing.
        drive_run(1'b1, 4);
        drive_run(1'b1, 5);
        drive_run(1'b0, 2);
        drive_run(1'b1, 10);
        drive_run(1'b0, 8);

        // Fall acceptance colliding with hold saturation.
        drive_run(1'b1, 4);
        drive_run(1'b1, 6);
        drive_run(1'b0, 6);

        // Reset during a rise check, then reset while held.
        drive_run(1'b1, 2);
        drive(1'b1, 1'b1);
        drive_run(1'b1, 6);
        drive_run(1'b1, 14);
        drive(1'b1, 1'b1);
        drive_run(1'b1, 6);
        drive_run(1'b0, 8);

        // Randomized bursts: short runs make bounce, long runs exercise hold.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                drive($urandom_range(0, 1) == 1, 1'b1);
            end else begin
                if ($urandom_range(0, 3) == 0) n = $urandom_range(4, 16);
                else n = $urandom_range(1, 5);
                drive_run($urandom_range(0, 1) == 1, n);
            end
        end

        drive_run(1'b0, 2);

        // Let the monitor drain, with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
